// File: rtl/iod_cmd_if.sv
// Command handshake between the PHY training engine and the IOD delay-line controller.
interface iod_cmd_if #(
    parameter int unsigned TapW = 8
) ();
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic            cmd_dir;
    logic [TapW-1:0] cmd_arg;
    logic            done;
    logic            err;
    logic            busy;
    logic [TapW-1:0] tap_pos;

    modport master (
        output cmd_valid, cmd_op, cmd_dir, cmd_arg,
        input  cmd_ready, done, err, busy, tap_pos
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dir, cmd_arg,
        output cmd_ready, done, err, busy, tap_pos
    );
endinterface

// File: rtl/iod_delay_line_ctrl.sv
// Sequences LOAD/MOVE/DIRECTION pulses for one DDR4 lane IOD delay line and tracks the tap.
// All outputs are registered from the next-state decode.
module iod_delay_line_ctrl #(
    parameter int unsigned TapW         = 8,
    parameter int unsigned MaxTap       = 255,
    parameter int unsigned InitTap      = 1,
    parameter int unsigned SettleCycles = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    iod_cmd_if.slave cmd,
    output logic     delay_line_load_o,
    output logic     delay_line_move_o,
    output logic     delay_line_direction_o,
    input  logic     delay_line_out_of_range_i
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLoadp  = 3'd1;
    localparam logic [2:0] StSetup  = 3'd2;
    localparam logic [2:0] StPulse  = 3'd3;
    localparam logic [2:0] StSettle = 3'd4;
    localparam logic [2:0] StFin    = 3'd5;

    localparam logic [1:0] OpLoad = 2'b00;
    localparam logic [1:0] OpStep = 2'b01;
    localparam logic [1:0] OpSet  = 2'b10;

    localparam logic [TapW-1:0] MaxTapT    = TapW'(MaxTap);
    localparam logic [TapW-1:0] InitTapT   = TapW'(InitTap);
    localparam logic [3:0]      SettleLast = 4'(SettleCycles - 1);

    logic [2:0]      state_q, state_d;
    logic [TapW-1:0] rem_q, rem_d;
    logic [TapW-1:0] tap_q, tap_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            dir_q, dir_d;
    logic            err_q, err_d;
    logic            ready_q, done_q, busy_q, load_q, move_q, direction_q;

    logic            accept;
    logic [TapW:0]   diff;
    logic [TapW-1:0] tap_nxt;
    logic [TapW-1:0] rem_nxt;

    // True when one more step in direction `up` would leave [0, MaxTap].
    function automatic logic at_bound(input logic [TapW-1:0] tap, input logic up);
        return up ? (tap >= MaxTapT) : (tap == '0);
    endfunction

    assign accept = cmd.cmd_valid & ready_q;
    // Borrow bit of the widened subtract gives the SET_ABS direction.
    assign diff   = {1'b0, cmd.cmd_arg} - {1'b0, tap_q};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tap_d   = tap_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        err_d   = err_q;
        tap_nxt = dir_q ? tap_q + TapW'(1) : tap_q - TapW'(1);
        rem_nxt = rem_q - TapW'(1);
        case (state_q)
            StIdle: begin
                if (accept) begin
                    err_d = 1'b0;
                    case (cmd.cmd_op)
                        OpLoad: begin
                            state_d = StLoadp;
                            tap_d   = InitTapT;
                        end
                        OpStep: begin
                            rem_d   = cmd.cmd_arg;
                            dir_d   = cmd.cmd_dir;
                            state_d = (cmd.cmd_arg == '0) ? StFin : StSetup;
                        end
                        OpSet: begin
                            if (cmd.cmd_arg > MaxTapT) begin
                                err_d   = 1'b1;
                                state_d = StFin;
                            end else begin
                                dir_d   = ~diff[TapW] & (diff[TapW-1:0] != '0);
                                rem_d   = diff[TapW] ? ('0 - diff[TapW-1:0]) : diff[TapW-1:0];
                                state_d = StSetup;
                            end
                        end
                        default: state_d = StFin;
                    endcase
                end
            end
            StLoadp: state_d = StFin;
            StSetup: begin
                if (rem_q == '0) begin
                    state_d = StFin;
                end else if (at_bound(tap_q, dir_q)) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    state_d = StPulse;
                end
            end
            StPulse: begin
                cnt_d   = SettleLast;
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (delay_line_out_of_range_i) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    tap_d = tap_nxt;
                    rem_d = rem_nxt;
                    if (rem_nxt == '0) begin
                        state_d = StFin;
                    end else if (at_bound(tap_nxt, dir_q)) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        state_d = StPulse;
                    end
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            tap_q       <= InitTapT;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            load_q      <= 1'b0;
            move_q      <= 1'b0;
            direction_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            tap_q       <= tap_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
            ready_q     <= (state_d == StIdle);
            done_q      <= (state_d == StFin);
            busy_q      <= (state_d != StIdle);
            load_q      <= (state_d == StLoadp);
            move_q      <= (state_d == StPulse);
            direction_q <= dir_d & ((state_d == StSetup) | (state_d == StPulse) |
                                    (state_d == StSettle));
        end
    end

    assign cmd.cmd_ready          = ready_q;
    assign cmd.done               = done_q;
    assign cmd.err                = err_q;
    assign cmd.busy               = busy_q;
    assign cmd.tap_pos            = tap_q;
    assign delay_line_load_o      = load_q;
    assign delay_line_move_o      = move_q;
    assign delay_line_direction_o = direction_q;

endmodule

// File: tb/tb_iod_delay_line_ctrl.sv
// Directed bench for iod_delay_line_ctrl with SETTLE_CYCLES=4.
module tb_iod_delay_line_ctrl;
    localparam int unsigned TapW = 8;
    localparam int          S    = 4;

    logic clk = 1'b0;
    logic rst;
    logic dl_load, dl_move, dl_dir, dl_oor;

    always #5 clk = ~clk;

    iod_cmd_if #(.TapW(TapW)) cmd ();

    iod_delay_line_ctrl #(
        .TapW        (TapW),
        .MaxTap      (255),
        .InitTap     (1),
        .SettleCycles(S)
    ) dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .cmd                      (cmd),
        .delay_line_load_o        (dl_load),
        .delay_line_move_o        (dl_move),
        .delay_line_direction_o   (dl_dir),
        .delay_line_out_of_range_i(dl_oor)
    );

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int move_cyc[$];
    bit move_dir[$];
    int load_cyc[$];
    int last_move = -100;
    int gap_viol  = 0;
    int overlap   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dl_move) begin
            move_cyc.push_back(cyc);
            move_dir.push_back(dl_dir);
            if (cyc - last_move < S + 1) gap_viol <= gap_viol + 1;
            last_move <= cyc;
        end
        if (dl_load) load_cyc.push_back(cyc);
        if (dl_load && dl_move) overlap <= overlap + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command; returns accept cycle and DONE cycle (-1 on timeout).
    task automatic send(input logic [1:0] op, input logic d, input logic [7:0] arg,
                        input int oor_from, output int t, output int done_at);
        int i;
        done_at = -1;
        move_cyc.delete();
        move_dir.delete();
        load_cyc.delete();
        @(negedge clk);
        for (i = 0; i < 50 && !cmd.cmd_ready; i++) @(negedge clk);
        check_eq("ready_before_cmd", cmd.cmd_ready, 1);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = op;
        cmd.cmd_dir   = d;
        cmd.cmd_arg   = arg;
        t = cyc;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            cmd.cmd_valid = 1'b0;
            if (oor_from > 0) dl_oor = (cyc >= t + oor_from) && (cyc < t + oor_from + S);
            if (cmd.done) begin
                done_at = cyc;
                break;
            end
        end
        dl_oor = 1'b0;
        if (done_at < 0) check_eq("done_timeout", 0, 1);
    endtask

    task automatic check_moves(input string tag, input int t, input int n, input bit d);
        check_eq({tag, "_count"}, move_cyc.size(), n);
        for (int k = 0; k < n && k < move_cyc.size(); k++) begin
            check_eq({tag, "_cycle"}, move_cyc[k] - t, 2 + k * (1 + S));
            check_eq({tag, "_dir"}, move_dir[k], d);
        end
    endtask

    int t, dn;

    initial begin
        rst           = 1'b1;
        dl_oor        = 1'b0;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = 2'b00;
        cmd.cmd_dir   = 1'b0;
        cmd.cmd_arg   = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", cmd.cmd_ready, 0);
        check_eq("rst_tap", cmd.tap_pos, 1);
        check_eq("rst_busy", cmd.busy, 0);
        check_eq("rst_done", cmd.done, 0);
        check_eq("rst_err", cmd.err, 0);
        check_eq("rst_pulses", {dl_load, dl_move, dl_dir}, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", cmd.cmd_ready, 1);

        // LOAD
        send(2'b00, 1'b0, 8'd0, 0, t, dn);
        check_eq("load_count", load_cyc.size(), 1);
        if (load_cyc.size() > 0) check_eq("load_cycle", load_cyc[0] - t, 1);
        check_eq("load_done_lat", dn - t, 2);
        check_eq("load_tap", cmd.tap_pos, 1);
        check_eq("load_err", cmd.err, 0);
        check_eq("load_moves", move_cyc.size(), 0);

        // STEP +3 from 1
        send(2'b01, 1'b1, 8'd3, 0, t, dn);
        check_moves("step_up", t, 3, 1'b1);
        check_eq("step_up_done_lat", dn - t, 17);
        check_eq("step_up_busy_fin", cmd.busy, 1);
        check_eq("step_up_tap", cmd.tap_pos, 4);
        check_eq("step_up_err", cmd.err, 0);

        // SET_ABS 2 from 4, then again
        send(2'b10, 1'b0, 8'd2, 0, t, dn);
        check_moves("set_down", t, 2, 1'b0);
        check_eq("set_down_done_lat", dn - t, 12);
        check_eq("set_down_tap", cmd.tap_pos, 2);
        send(2'b10, 1'b1, 8'd2, 0, t, dn);
        check_eq("set_same_done_lat", dn - t, 2);
        check_eq("set_same_moves", move_cyc.size(), 0);
        check_eq("set_same_tap", cmd.tap_pos, 2);

        // STEP -5 from 2 hits the lower bound after 2 pulses
        send(2'b01, 1'b0, 8'd5, 0, t, dn);
        check_moves("step_bound", t, 2, 1'b0);
        check_eq("step_bound_done_lat", dn - t, 12);
        check_eq("step_bound_tap", cmd.tap_pos, 0);
        check_eq("step_bound_err", cmd.err, 1);
        @(negedge clk);
        check_eq("err_sticky", cmd.err, 1);

        // Reserved op clears ERR, DONE only
        send(2'b11, 1'b0, 8'd7, 0, t, dn);
        check_eq("nop_done_lat", dn - t, 1);
        check_eq("nop_err", cmd.err, 0);
        check_eq("nop_moves", move_cyc.size(), 0);
        check_eq("nop_tap", cmd.tap_pos, 0);

        // STEP +4 with OUT_OF_RANGE during the second settle
        send(2'b01, 1'b1, 8'd4, 8, t, dn);
        check_moves("oor", t, 2, 1'b1);
        check_eq("oor_done_lat", dn - t, 12);
        check_eq("oor_tap", cmd.tap_pos, 1);
        check_eq("oor_err", cmd.err, 1);

        // Reset asserted mid-SETTLE
        move_cyc.delete();
        move_dir.delete();
        @(negedge clk);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = 2'b01;
        cmd.cmd_dir   = 1'b1;
        cmd.cmd_arg   = 8'd3;
        t = cyc;
        @(negedge clk);
        cmd.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("arst_pre_busy", cmd.busy, 1);
        check_eq("arst_pre_dir", dl_dir, 1);
        rst = 1'b1;
        #1;
        check_eq("arst_ready", cmd.cmd_ready, 0);
        check_eq("arst_busy", cmd.busy, 0);
        check_eq("arst_err", cmd.err, 0);
        check_eq("arst_done", cmd.done, 0);
        check_eq("arst_pulses", {dl_load, dl_move, dl_dir}, 0);
        check_eq("arst_tap", cmd.tap_pos, 1);
        check_eq("arst_moves_before", move_cyc.size(), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        move_cyc.delete();
        repeat (20) @(negedge clk);
        check_eq("arst_no_moves_after", move_cyc.size(), 0);
        check_eq("arst_ready_after", cmd.cmd_ready, 1);
        check_eq("arst_tap_after", cmd.tap_pos, 1);

        check_eq("move_spacing_viol", gap_viol, 0);
        check_eq("load_move_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
